// File: rtl/program_loader_if.sv
// Byte-stream handshake from the UART receiver into the program loader.
// A transfer happens on a clock edge where rx_valid and rx_ready are both high.
interface program_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/program_loader.sv
// Fills instruction memory from a command byte stream and gates the pipeline enable.
// 'L' N <4N bytes MSB first> loads words from address 0; 'R'/'S'/'H' run, step or halt.
module program_loader #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 32,
  parameter logic [7:0]  CMD_LOAD = 8'h4C,
  parameter logic [7:0]  CMD_RUN  = 8'h52,
  parameter logic [7:0]  CMD_STEP = 8'h53,
  parameter logic [7:0]  CMD_HALT = 8'h48
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.slave   rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              pipe_enable,
  output logic              pipe_rst,
  output logic              busy,
  output logic              load_done
);

  typedef enum logic [2:0] {StIdle, StGetCount, StGetBytes, StWrite, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] n_trunc;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              step_q, step_d;
  logic              accept;
  logic              last_word;

  assign rx.rx_ready = rst && (state_q != StWrite);
  assign accept      = rx.rx_valid && rx.rx_ready;
  assign n_trunc     = ADDR_W'(rx.rx_data);
  assign last_word   = (count_q == (ADDR_W + 1)'(1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    step_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (rx.rx_data == CMD_LOAD)      state_d = StGetCount;
          else if (rx.rx_data == CMD_RUN)  state_d = StRun;
          else if (rx.rx_data == CMD_STEP) step_d  = 1'b1;
        end
      end
      StRun: begin
        if (accept) begin
          if (rx.rx_data == CMD_LOAD) state_d = StGetCount;
          else if (rx.rx_data == CMD_HALT || rx.rx_data == CMD_STEP) state_d = StIdle;
        end
      end
      StGetCount: begin
        if (accept) begin
          // A truncated count of zero means a full memory image.
          count_d = (n_trunc == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, n_trunc};
          idx_d   = 2'd0;
          addr_d  = '0;
          state_d = StGetBytes;
        end
      end
      StGetBytes: begin
        if (accept) begin
          word_d = {word_q[DATA_W-9:0], rx.rx_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        count_d = count_q - (ADDR_W + 1)'(1);
        addr_d  = addr_q + ADDR_W'(1);
        state_d = last_word ? StIdle : StGetBytes;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      idx_q   <= 2'd0;
      word_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      step_q  <= step_d;
    end
  end

  assign imem_we     = (state_q == StWrite);
  assign imem_addr   = addr_q;
  assign imem_wdata  = word_q;
  assign pipe_enable = (state_q == StRun) || step_q;
  assign busy        = (state_q == StGetCount) || (state_q == StGetBytes) || (state_q == StWrite);
  assign load_done   = imem_we && last_word;
  assign pipe_rst    = !load_done;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, directed corner cases and
// random command streams checked against a transaction-level model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_we;
  logic [6:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        pipe_enable;
  logic        pipe_rst;
  logic        busy;
  logic        load_done;

  always #5 clk = ~clk;

  program_loader_if rx_if ();

  program_loader dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx_if),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .pipe_enable (pipe_enable),
    .pipe_rst    (pipe_rst),
    .busy        (busy),
    .load_done   (load_done)
  );

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  typedef struct {
    logic [7:0] b;
    logic       en;
    logic       bz;
    int         stall;
  } vec_t;

  int  checks   = 0;
  int  failures = 0;
  int  n_writes = 0;
  int  n_done   = 0;
  wr_t exp_q[$];

  // Reference model: command parser over whole bytes, no notion of RTL states.
  bit          m_running;
  bit          m_await_count;
  int          m_words_left;
  int          m_nbytes;
  logic [6:0]  m_addr;
  logic [31:0] m_word;

  vec_t       tbl[17];
  logic [7:0] b2[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_running     = 1'b0;
    m_await_count = 1'b0;
    m_words_left  = 0;
    m_nbytes      = 0;
    m_addr        = '0;
    m_word        = '0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, output logic en, output logic bz);
    wr_t w;
    if (m_await_count) begin
      m_await_count = 1'b0;
      m_words_left  = (b % 128 == 0) ? 128 : int'(b % 128);
      m_nbytes      = 0;
      m_addr        = '0;
      en = 1'b0;
      bz = 1'b1;
    end else if (m_words_left > 0) begin
      m_word = (m_word << 8) | 32'(b);
      m_nbytes++;
      if (m_nbytes == 4) begin
        w.addr = m_addr;
        w.data = m_word;
        w.last = (m_words_left == 1);
        exp_q.push_back(w);
        m_addr = m_addr + 7'd1;
        m_words_left--;
        m_nbytes = 0;
      end
      en = 1'b0;
      bz = 1'b1;
    end else begin
      bz = 1'b0;
      case (b)
        8'h4C: begin m_await_count = 1'b1; m_running = 1'b0; en = 1'b0; bz = 1'b1; end
        8'h52: begin m_running = 1'b1; en = 1'b1; end
        8'h48: begin m_running = 1'b0; en = 1'b0; end
        8'h53: begin en = !m_running; m_running = 1'b0; end
        default: en = m_running;
      endcase
    end
  endfunction

  // Advance one cycle and check any write strobe against the expected-write queue.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) begin
      n_writes++;
      if (load_done === 1'b1) n_done++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr,
                 imem_wdata);
      end else begin
        w = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(w.addr));
        check("write_data", imem_wdata, w.data);
        check("write_load_done", 32'(load_done), 32'(w.last));
        check("write_pipe_rst", 32'(pipe_rst), 32'(!w.last));
      end
    end else begin
      check("nowrite_load_done", 32'(load_done), 32'd0);
      check("nowrite_pipe_rst", 32'(pipe_rst), 32'd1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int stalls, output logic en,
                           output logic bz);
    logic acc;
    logic exp_en;
    logic exp_bz;
    acc    = 1'b0;
    stalls = 0;
    exp_en = 1'b0;
    exp_bz = 1'b0;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = b;
    while (!acc) begin
      if (stalls > 20) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got no accept of %0h expected accept within 20 cycles", b);
        rx_if.rx_valid = 1'b0;
        en = pipe_enable;
        bz = busy;
        return;
      end
      acc = rx_if.rx_ready;
      if (acc) model_byte(b, exp_en, exp_bz);
      tick();
      if (!acc) stalls++;
    end
    rx_if.rx_valid = 1'b0;
    check("pipe_enable", 32'(pipe_enable), 32'(exp_en));
    check("busy", 32'(busy), 32'(exp_bz));
    en = pipe_enable;
    bz = busy;
  endtask

  task automatic send(input logic [7:0] b);
    int   st;
    logic en;
    logic bz;
    send_byte(b, st, en, bz);
  endtask

  task automatic do_load(input logic [7:0] nb, input int words);
    send(8'h4C);
    send(nb);
    for (int i = 0; i < words * 4; i++) send(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_if.rx_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_pipe_enable"}, 32'(pipe_enable), 32'd0);
    check({tag, "_pipe_rst"}, 32'(pipe_rst), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   st;
    int   w0;
    int   d0;
    int   r;
    logic en;
    logic bz;

    tbl = '{
      '{8'h52, 1'b1, 1'b0, 0}, '{8'h41, 1'b1, 1'b0, 0}, '{8'h48, 1'b0, 1'b0, 0},
      '{8'h48, 1'b0, 1'b0, 0}, '{8'h53, 1'b1, 1'b0, 0}, '{8'h53, 1'b1, 1'b0, 0},
      '{8'h52, 1'b1, 1'b0, 0}, '{8'h53, 1'b0, 1'b0, 0}, '{8'h45, 1'b0, 1'b0, 0},
      '{8'h52, 1'b1, 1'b0, 0}, '{8'h4C, 1'b0, 1'b1, 0}, '{8'h01, 1'b0, 1'b1, 0},
      '{8'h12, 1'b0, 1'b1, 0}, '{8'h34, 1'b0, 1'b1, 0}, '{8'h56, 1'b0, 1'b1, 0},
      '{8'h78, 1'b0, 1'b1, 0}, '{8'h53, 1'b1, 1'b0, 1}
    };
    b2 = '{8'h4C, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    rst            = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    m_reset();

    // Reset held two cycles.
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();
    check("ready_after_reset", 32'(rx_if.rx_ready), 32'd1);

    // Vector table: run/halt/step, load while running, stall through WRITE.
    for (int i = 0; i < 17; i++) begin
      send_byte(tbl[i].b, st, en, bz);
      check($sformatf("tbl%0d_en", i), 32'(en), 32'(tbl[i].en));
      check($sformatf("tbl%0d_busy", i), 32'(bz), 32'(tbl[i].bz));
      check($sformatf("tbl%0d_stall", i), 32'(st), 32'(tbl[i].stall));
    end
    tick();
    check("step_width", 32'(pipe_enable), 32'd0);

    // Two-word load with fixed data.
    d0 = n_done;
    w0 = n_writes;
    for (int i = 0; i < 10; i++) send(b2[i]);
    tick();
    check("load2_busy_after", 32'(busy), 32'd0);
    check("load2_writes", 32'(n_writes - w0), 32'd2);
    check("load2_done_count", 32'(n_done - d0), 32'd1);

    // Free run holds enable until halt.
    send(8'h52);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("run_hold", 32'(pipe_enable), 32'd1);
    end
    send(8'h48);
    tick();
    check("halt_hold", 32'(pipe_enable), 32'd0);

    // Full-memory load with count 0.
    w0 = n_writes;
    d0 = n_done;
    do_load(8'h00, 128);
    tick();
    tick();
    check("full_writes", 32'(n_writes - w0), 32'd128);
    check("full_done_count", 32'(n_done - d0), 32'd1);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);

    // Count 0x81 truncates to one word.
    w0 = n_writes;
    do_load(8'h81, 1);
    tick();
    check("trunc_writes", 32'(n_writes - w0), 32'd1);

    // Abort mid-load by reset, then reload from address 0.
    w0 = n_writes;
    send(8'h4C); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    rst = 1'b0;
    m_reset();
    tick();
    check_reset_outputs("abort");
    check("abort_writes", 32'(n_writes - w0), 32'd1);
    rst = 1'b1;
    tick();
    w0 = n_writes;
    do_load(8'h01, 1);
    tick();
    check("reload_writes", 32'(n_writes - w0), 32'd1);

    // Random command streams against the model.
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    send(8'h52);
        2:       send(8'h48);
        3, 4:    send(8'h53);
        5:       do_load(8'($urandom_range(1, 3)), 0);
        default: send(8'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("gap_enable", 32'(pipe_enable), 32'(m_running));
        check("gap_busy", 32'(busy), 32'(m_await_count || m_words_left > 0));
      end
    end
    tick();
    tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
